// File: rtl/lsu_pkg.sv
// Shared load/store encodings and the LSU state type.
package lsu_pkg;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, extraction/extension for loads, and legality check.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic        store,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_lane,
    output logic [31:0] ldata,
    output logic        fault
);

    logic [31:0] shifted;

    always_comb begin
        wstrb      = '0;
        wdata_lane = '0;
        ldata      = '0;
        fault      = 1'b0;
        shifted    = rdata >> {offset, 3'b000};
        case (funct3)
            LS_B: begin
                wstrb      = 4'b0001 << offset;
                wdata_lane = {4{wdata[7:0]}};
                ldata      = {{24{shifted[7]}}, shifted[7:0]};
            end
            LS_BU: begin
                ldata = {24'h0, shifted[7:0]};
                fault = store;
            end
            LS_H: begin
                wstrb      = 4'b0011 << offset;
                wdata_lane = {2{wdata[15:0]}};
                ldata      = {{16{shifted[15]}}, shifted[15:0]};
                fault      = offset[0];
            end
            LS_HU: begin
                ldata = {16'h0, shifted[15:0]};
                fault = offset[0] | store;
            end
            LS_W: begin
                wstrb      = 4'b1111;
                wdata_lane = wdata;
                ldata      = rdata;
                fault      = (offset != 2'b00);
            end
            default: fault = 1'b1;
        endcase
        if (!store) begin
            wstrb = '0;
        end
    end

endmodule

// File: rtl/lsu.sv
// Single-outstanding load/store unit: latches one op, runs one word-bus
// transaction, and hands the extended result (or fault) to writeback.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_wdata,
    input  logic [2:0]      in_funct3,
    input  logic            in_store,
    input  logic [4:0]      in_rd,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_wstrb,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_fault
);

    lsu_state_t state_q, state_d;

    logic [XLEN-1:0] addr_q, wdata_q, ldata_q;
    logic [2:0]      funct3_q;
    logic            store_q, fault_q;
    logic [4:0]      rd_q;

    logic [2:0]      al_funct3;
    logic [1:0]      al_off;
    logic            al_store;
    logic [XLEN-1:0] al_wdata;
    logic [3:0]      al_wstrb;
    logic [XLEN-1:0] al_wlane, al_ldata;
    logic            al_fault;

    // While idle the aligner sees the live inputs so the fault verdict is
    // available in the accept cycle; afterwards it sees the latched op.
    always_comb begin
        al_funct3 = funct3_q;
        al_off    = addr_q[1:0];
        al_store  = store_q;
        al_wdata  = wdata_q;
        if (state_q == IDLE) begin
            al_funct3 = in_funct3;
            al_off    = in_addr[1:0];
            al_store  = in_store;
            al_wdata  = in_wdata;
        end
    end

    lsu_align u_align (
        .funct3     (al_funct3),
        .offset     (al_off),
        .store      (al_store),
        .wdata      (al_wdata),
        .rdata      (mem_rdata),
        .wstrb      (al_wstrb),
        .wdata_lane (al_wlane),
        .ldata      (al_ldata),
        .fault      (al_fault)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            ldata_q  <= '0;
            funct3_q <= '0;
            store_q  <= 1'b0;
            fault_q  <= 1'b0;
            rd_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && in_valid) begin
                addr_q   <= in_addr;
                wdata_q  <= in_wdata;
                funct3_q <= in_funct3;
                store_q  <= in_store;
                rd_q     <= in_rd;
                fault_q  <= al_fault;
                ldata_q  <= '0;
            end
            if (state_q == WAIT && mem_rvalid) begin
                ldata_q <= al_ldata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = al_fault ? RESP : REQ;
            REQ:     if (mem_gnt) state_d = store_q ? RESP : WAIT;
            WAIT:    if (mem_rvalid) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wstrb = '0;
        mem_wdata = '0;
        wb_valid  = 1'b0;
        wb_rd     = '0;
        wb_data   = '0;
        wb_fault  = 1'b0;
        if (state_q == REQ) begin
            mem_req   = 1'b1;
            mem_we    = store_q;
            mem_addr  = {addr_q[XLEN-1:2], 2'b00};
            mem_wstrb = al_wstrb;
            mem_wdata = store_q ? al_wlane : '0;
        end
        if (state_q == RESP) begin
            wb_valid = 1'b1;
            wb_rd    = store_q ? 5'd0 : rd_q;
            wb_data  = ldata_q;
            wb_fault = fault_q;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed table, hand sequences and randomized ops against a behavioural model of the LSU.
module tb_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_store;
    logic [31:0] in_addr, in_wdata;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        wb_valid, wb_fault;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    always #5 clk = ~clk;

    lsu #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_wdata(in_wdata), .in_funct3(in_funct3), .in_store(in_store), .in_rd(in_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_fault(wb_fault)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic        store;
        logic [4:0]  rd;
        int          gnt_dly;
        int          rv_dly;
        logic [31:0] rdata;
    } op_t;

    typedef struct {
        logic        fault;
        logic [3:0]  wstrb;
        logic [31:0] mwdata;
        logic [31:0] wbdata;
        int          lat;
    } exp_t;

    typedef struct {
        op_t  op;
        exp_t ex;
    } vec_t;

    typedef struct {
        int          wb_cyc;
        int          req_cycles;
        bit          stable;
        bit          timeout;
        bit          pulse_ok;
        bit          ready_at_accept;
        logic [31:0] maddr;
        logic        mwe;
        logic [3:0]  mwstrb;
        logic [31:0] mwdata;
        logic [4:0]  wrd;
        logic [31:0] wdata;
        logic        wfault;
    } res_t;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Expected behaviour derived from access size, alignment and legality rules.
    function automatic exp_t model(input op_t op);
        exp_t  e;
        int    size, off, bits;
        bit    legal, signed_ld;
        longint v;
        e = '{fault: 1'b0, wstrb: 4'h0, mwdata: 32'h0, wbdata: 32'h0, lat: 0};
        off = int'(op.addr % 4);
        case (op.f3)
            LS_B, LS_BU: size = 1;
            LS_H, LS_HU: size = 2;
            LS_W:        size = 4;
            default:     size = 0;
        endcase
        legal = (size != 0) && !(op.store && (op.f3 == LS_BU || op.f3 == LS_HU));
        e.fault = !legal || ((off % (size == 0 ? 1 : size)) != 0);
        if (e.fault) begin
            e.lat = 2;
        end else if (op.store) begin
            e.wstrb = 4'(((1 << size) - 1) << off);
            for (int i = 0; i < 4; i++) e.mwdata[8*i +: 8] = op.wdata[8*(i % size) +: 8];
            e.lat = 3 + op.gnt_dly;
        end else begin
            bits = 8 * size;
            v = (longint'(op.rdata) >> (8 * off)) & ((64'd1 << bits) - 1);
            signed_ld = (op.f3 == LS_B || op.f3 == LS_H);
            if (signed_ld && size < 4 && ((v >> (bits - 1)) & 1) == 1) v = v - (64'sd1 <<< bits);
            e.wbdata = v[31:0];
            e.lat = 4 + op.gnt_dly + op.rv_dly;
        end
        return e;
    endfunction

    // Presents one op, plays the bus (junk rvalid in the grant cycle), records what the DUT did.
    task automatic run_op(input op_t op, output res_t r);
        int  rq, rvw, cyc;
        bit  granted, delivered;
        r = '{default: '0};
        rq = 0; rvw = 0; granted = 0; delivered = 0;
        in_valid = 1'b1; in_addr = op.addr; in_wdata = op.wdata;
        in_funct3 = op.f3; in_store = op.store; in_rd = op.rd;
        r.ready_at_accept = in_ready;
        @(posedge clk); #1;
        in_valid = 1'b0; in_addr = $urandom; in_wdata = $urandom;
        in_funct3 = 3'($urandom); in_store = 1'($urandom); in_rd = 5'($urandom);
        cyc = 2;
        r.timeout = 1;
        for (int i = 0; i < 60; i++) begin
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
            if (wb_valid) begin
                r.wb_cyc = cyc; r.wrd = wb_rd; r.wdata = wb_data; r.wfault = wb_fault;
                r.timeout = 0;
                break;
            end
            if (mem_req) begin
                if (rq == 0) begin
                    r.maddr = mem_addr; r.mwe = mem_we; r.mwstrb = mem_wstrb; r.mwdata = mem_wdata;
                    r.stable = 1;
                end else if ({mem_addr, mem_we, mem_wstrb, mem_wdata} !== {r.maddr, r.mwe, r.mwstrb, r.mwdata}) begin
                    r.stable = 0;
                end
                rq++;
                if (rq == op.gnt_dly + 1) begin
                    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = ~op.rdata; granted = 1;
                end
            end else if (granted && !delivered) begin
                if (rvw == op.rv_dly) begin
                    mem_rvalid = 1'b1; mem_rdata = op.rdata; delivered = 1;
                end
                rvw++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        r.req_cycles = rq;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        if (!r.timeout) begin
            @(posedge clk); #1;
            r.pulse_ok = !wb_valid && in_ready;
        end
    endtask

    task automatic check_op(input string tag, input op_t op, input exp_t e, input res_t r);
        check({tag, ".timeout"}, 32'(r.timeout), 32'd0);
        check({tag, ".ready"}, 32'(r.ready_at_accept), 32'd1);
        check({tag, ".lat"}, 32'(r.wb_cyc), 32'(e.lat));
        check({tag, ".fault"}, 32'(r.wfault), 32'(e.fault));
        check({tag, ".wb_rd"}, 32'(r.wrd), op.store ? 32'd0 : 32'(op.rd));
        check({tag, ".wb_data"}, r.wdata, e.wbdata);
        check({tag, ".req_cycles"}, 32'(r.req_cycles), e.fault ? 32'd0 : 32'(op.gnt_dly + 1));
        check({tag, ".pulse"}, 32'(r.pulse_ok), 32'd1);
        if (!e.fault) begin
            check({tag, ".mem_addr"}, r.maddr, op.addr & 32'hFFFF_FFFC);
            check({tag, ".mem_we"}, 32'(r.mwe), 32'(op.store));
            check({tag, ".wstrb"}, 32'(r.mwstrb), 32'(e.wstrb));
            check({tag, ".stable"}, 32'(r.stable), 32'd1);
            if (op.store) check({tag, ".mem_wdata"}, r.mwdata, e.mwdata);
        end
    endtask

    vec_t  vt[13];
    op_t   op;
    exp_t  ex;
    res_t  res;
    logic [31:0] a;
    int    idx, wbn, rdyn, late_wb;
    bit    pend, accept;

    initial begin
        //            addr          wdata         f3     st    rd     g  r  rdata                fault  wstrb    mwdata         wbdata         lat
        vt[0]  = '{'{32'h0000_1003, 32'h0,        LS_B,  1'b0, 5'd5,  0, 0, 32'h80AA_BBCC}, '{1'b0, 4'b0000, 32'h0,         32'hFFFF_FF80, 4}};
        vt[1]  = '{'{32'h0000_2002, 32'h1234_ABCD, LS_H, 1'b1, 5'd9,  2, 0, 32'h0},         '{1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0,         5}};
        vt[2]  = '{'{32'h0000_0010, 32'h0,        LS_HU, 1'b0, 5'd3,  0, 0, 32'hDEAD_BEEF}, '{1'b0, 4'b0000, 32'h0,         32'h0000_BEEF, 4}};
        vt[3]  = '{'{32'h0000_0010, 32'h0,        LS_W,  1'b0, 5'd4,  0, 0, 32'hDEAD_BEEF}, '{1'b0, 4'b0000, 32'h0,         32'hDEAD_BEEF, 4}};
        vt[4]  = '{'{32'h0000_1002, 32'h0,        LS_W,  1'b0, 5'd6,  0, 0, 32'h1111_1111}, '{1'b1, 4'b0000, 32'h0,         32'h0,         2}};
        vt[5]  = '{'{32'h0000_1001, 32'h0,        LS_H,  1'b0, 5'd7,  0, 0, 32'h2222_2222}, '{1'b1, 4'b0000, 32'h0,         32'h0,         2}};
        vt[6]  = '{'{32'h0000_3000, 32'hFFFF_FFFF, LS_BU, 1'b1, 5'd8, 0, 0, 32'h0},         '{1'b1, 4'b0000, 32'h0,         32'h0,         2}};
        vt[7]  = '{'{32'h0000_2001, 32'h0,        LS_B,  1'b0, 5'd10, 1, 2, 32'h0000_7F00}, '{1'b0, 4'b0000, 32'h0,         32'h0000_007F, 7}};
        vt[8]  = '{'{32'h0000_2002, 32'h0,        LS_H,  1'b0, 5'd11, 0, 1, 32'h8001_0000}, '{1'b0, 4'b0000, 32'h0,         32'hFFFF_8001, 5}};
        vt[9]  = '{'{32'h0000_4001, 32'hAABB_CC5A, LS_B, 1'b1, 5'd12, 1, 0, 32'h0},         '{1'b0, 4'b0010, 32'h5A5A_5A5A, 32'h0,         4}};
        vt[10] = '{'{32'h0000_4000, 32'hCAFE_F00D, LS_W, 1'b1, 5'd13, 0, 0, 32'h0},         '{1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0,         3}};
        vt[11] = '{'{32'h0000_5000, 32'h0,        3'b011, 1'b0, 5'd14, 0, 0, 32'h0},        '{1'b1, 4'b0000, 32'h0,         32'h0,         2}};
        vt[12] = '{'{32'h0000_5002, 32'h0,        LS_BU, 1'b0, 5'd15, 0, 0, 32'h00F1_0000}, '{1'b0, 4'b0000, 32'h0,         32'h0000_00F1, 4}};

        rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_wdata = '0; in_funct3 = '0;
        in_store = 1'b0; in_rd = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.mem_req", 32'(mem_req), 32'd0);
        check("rst.wb_valid", 32'(wb_valid), 32'd0);
        check("rst.wb_fault", 32'(wb_fault), 32'd0);
        check("rst.outs", {mem_addr | mem_wdata | wb_data, 23'd0, mem_wstrb, wb_rd}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            run_op(vt[i].op, res);
            check_op($sformatf("vec%0d", i), vt[i].op, vt[i].ex, res);
        end

        // Back-to-back loads with in_valid held high.
        idx = 0; wbn = 0; rdyn = 0; pend = 0;
        in_valid = 1'b1; in_addr = 32'h100; in_funct3 = LS_W; in_store = 1'b0; in_rd = 5'd1;
        for (int c = 0; c < 40 && wbn < 3; c++) begin
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
            if (wb_valid) begin
                a = 32'h100 + 32'(4 * wbn);
                check($sformatf("b2b%0d.data", wbn), wb_data, {a[15:0], ~a[15:0]});
                check($sformatf("b2b%0d.rd", wbn), 32'(wb_rd), 32'(wbn + 1));
                wbn++;
            end
            if (mem_req) begin
                mem_gnt = 1'b1; a = mem_addr; pend = 1;
            end else if (pend) begin
                mem_rvalid = 1'b1; mem_rdata = {a[15:0], ~a[15:0]}; pend = 0;
            end
            accept = in_valid && in_ready;
            if (accept) rdyn++;
            @(posedge clk); #1;
            if (accept) begin
                idx++;
                if (idx < 3) begin
                    in_addr = 32'h100 + 32'(4 * idx); in_rd = 5'(idx + 1);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        check("b2b.wb_count", 32'(wbn), 32'd3);
        check("b2b.ready_count", 32'(rdyn), 32'd3);
        @(posedge clk); #1;

        // Reset while waiting for read data; the late rvalid must be ignored.
        in_valid = 1'b1; in_addr = 32'h40; in_funct3 = LS_W; in_store = 1'b0; in_rd = 5'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rstmid.req", 32'(mem_req), 32'd1);
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        check("rstmid.waiting", 32'({mem_req, in_ready}), 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rstmid.in_ready", 32'(in_ready), 32'd1);
        check("rstmid.mem_req", 32'(mem_req), 32'd0);
        check("rstmid.wb_valid", 32'(wb_valid), 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        late_wb = 0;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (wb_valid) late_wb++;
            @(posedge clk); #1;
        end
        check("rstmid.late_wb", 32'(late_wb), 32'd0);
        check("rstmid.idle", 32'(in_ready), 32'd1);

        // Randomized ops against the model.
        for (int i = 0; i < 200; i++) begin
            op.addr  = $urandom;
            op.wdata = $urandom;
            case ($urandom_range(0, 11))
                0, 1:    op.f3 = LS_B;
                2, 3:    op.f3 = LS_H;
                4, 5, 6: op.f3 = LS_W;
                7, 8:    op.f3 = LS_BU;
                9, 10:   op.f3 = LS_HU;
                default: op.f3 = 3'($urandom_range(6, 7));
            endcase
            if ($urandom_range(0, 2) != 0) op.addr[1:0] = (op.f3 == LS_W) ? 2'b00 :
                (op.f3 == LS_H || op.f3 == LS_HU) ? {op.addr[1], 1'b0} : op.addr[1:0];
            op.store   = 1'($urandom);
            op.rd      = 5'($urandom);
            op.gnt_dly = $urandom_range(0, 3);
            op.rv_dly  = $urandom_range(0, 3);
            op.rdata   = $urandom;
            ex = model(op);
            run_op(op, res);
            check_op($sformatf("rnd%0d", i), op, ex, res);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
